posit_encoder_32_3: RTL and testbench
=====================================

Name: posit_encoder_32_3

Overview:
- Pipelined posit(32,3) encoder, the inverse of the team's posit decoder.
- Accepts unpacked fields (sign, signed regime k, exponent, fraction, sticky) and produces a packed 32-bit posit word.
- Rounds to nearest-even and saturates to minpos/maxpos.
- Sits at the output of posit arithmetic units; valid/ready on both sides; throughput 1 result/cycle.

Parameters:
- N, 32, posit width
- ES, 3, exponent field width
- FS, N-3-ES (26), fraction field width (hidden bit excluded)
- RW, 6, width of signed regime value k

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder accepts input this cycle
- in_sign  in  1  sign of value
- in_k  in  RW  regime value, two's complement, range -32..31
- in_expo  in  ES  exponent
- in_frac  in  FS  fraction, MSB-aligned
- in_sticky  in  1  OR of all fraction bits below in_frac
- in_zero  in  1  value is exact zero
- in_nar  in  1  value is NaR; has priority over in_zero
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_posit  out  N  encoded posit
- out_sat  out  1  magnitude was clamped to minpos/maxpos

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Reset clears all stage valid bits. out_valid=0, out_posit=0, out_sat=0, in_ready=1 after reset release. Reset mid-operation discards all in-flight data; nothing is emitted afterwards.
- Transfers: input occurs when in_valid&in_ready; output occurs when out_valid&out_ready.
- Pipeline: 3 stages S1/S2/S3, latency exactly 3 cycles with no backpressure.
- Stage advance: stage i loads when it is empty or stage i+1 loads in the same cycle; S3 unloads on out_ready. in_ready = ~v1 | S1 advancing. Combinational ready chain is permitted; bubbles collapse.
- Holding: out_posit and out_sat stay stable while out_valid & ~out_ready.
- S1, regime build:
  - k>=0: regime string is k+1 ones then a zero (length k+2).
  - k<0: -k zeros then a one (length 1-k).
  - Clamp: k>=30 forces maxpos magnitude 0x7FFFFFFF; k<=-31 forces minpos 0x00000001. Both set sat.
  - Flags: capture nar/zero/sign.
- S2, assemble and round:
  - Form regime|expo|frac and keep the top N-1 bits as magnitude m.
  - g = first dropped bit. s = OR(remaining dropped bits, in_sticky).
  - Round up iff g & (s | m[0]).
  - If a non-clamped result rounds to 0, force 1 and set sat. Round-up past maxpos cannot occur: the k=29 carry yields exactly 0x7FFFFFFF.
  - When the string fits (k in -1..0), g=0 and there is no round-up.
- S3, sign and output:
  - out_posit = sign ? -{0,m} : {0,m} (N-bit two's complement).
  - nar gives 0x80000000; zero gives 0x00000000. Both force out_sat=0.
- Simultaneous in-transfer and out-transfer with all stages full: allowed; pipeline shifts by one.

Decomposition:
- Shared package posit_pkg: N, ES, FS, RW, constants NAR (0x80000000), MAXPOS (0x7FFFFFFF), MINPOS (0x00000001), K_MAX_CLAMP (30), K_MIN_CLAMP (-31).
- One sub-module: posit_round_rne (combinational: magnitude, g, s in; rounded magnitude and underflow flag out), reused by other posit units.

Test Plan:
- k=0, e=0, f=0, sign 0 -> 0x40000000; sign 1 -> 0xC0000000; sat=0; out_valid exactly 3 cycles after accept.
- k=-1, e=0, f=0 -> 0x20000000. k=29, e=3'b100, f=0, sticky=0 -> tie, even -> 0x7FFFFFFE. Same with e=3'b101 -> 0x7FFFFFFF, sat=0.
- k=31 -> 0x7FFFFFFF, sat=1. k=-32 with sign=1 -> 0xFFFFFFFF (−minpos), sat=1. in_nar=1 with in_zero=1 -> 0x80000000. in_zero=1 -> 0x00000000.
- Backpressure: stream 8 distinct inputs with out_ready low for cycles 4-9. Required: in_ready drops once all 3 stages are full, out_posit is held stable, all 8 results emerge in order with no loss or duplication.
- Full throughput: in_valid and out_ready held high for 20 cycles -> 20 results on consecutive cycles; in_ready stays 1.
- Assert rst_n low with 3 items in flight -> out_valid falls immediately (asynchronous). After release: no stale outputs, and a fresh input emerges after 3 cycles.

Source files
------------

// File: rtl/posit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : posit_pkg
// Description : Shared constants and stage payload types for posit(32,3)
//               units. Imported by the encoder and its rounding helper.
// Revision    : 1.0 - initial release
// ============================================================================
package posit_pkg;

    localparam int N  = 32;          // posit width
    localparam int ES = 3;           // exponent field width
    localparam int FS = N - 3 - ES;  // fraction field width, hidden bit excluded
    localparam int RW = 6;           // width of signed regime value k

    // Working width of the regime|expo|frac string before truncation to N-1
    // bits; wide enough that the longest non-clamped regime never shifts
    // body bits off the bottom.
    localparam int XW = 2 * N;

    localparam logic [N-1:0] NAR    = 32'h8000_0000;
    localparam logic [N-1:0] MAXPOS = 32'h7FFF_FFFF;
    localparam logic [N-1:0] MINPOS = 32'h0000_0001;

    localparam logic signed [RW-1:0] K_MAX_CLAMP = 6'sd30;
    localparam logic signed [RW-1:0] K_MIN_CLAMP = -6'sd31;

    // S1 -> S2: unrounded magnitude plus guard/sticky and clamp decisions
    typedef struct packed {
        logic          sign;
        logic          nar;
        logic          zero;
        logic          clamp_max;
        logic          clamp_min;
        logic [N-2:0]  m;
        logic          g;
        logic          s;
    } s1_t;

    // S2 -> S3: final unsigned magnitude and saturation flag
    typedef struct packed {
        logic          sign;
        logic          nar;
        logic          zero;
        logic          sat;
        logic [N-2:0]  m;
    } s2_t;

endpackage
`default_nettype wire

// File: rtl/posit_round_rne.sv
`default_nettype none
// ============================================================================
// Module      : posit_round_rne
// Description : Combinational round-to-nearest-even on a truncated posit
//               magnitude.
//   i_mag       : truncated magnitude (MW bits)
//   i_g         : first dropped bit (guard)
//   i_s         : OR of every bit below the guard
//   o_mag       : rounded magnitude, saturating at all-ones
//   o_underflow : rounded magnitude is zero
// Revision    : 1.0 - initial release
// ============================================================================
module posit_round_rne #(
    parameter int MW = 31
) (
    input  logic [MW-1:0] i_mag,
    input  logic          i_g,
    input  logic          i_s,
    output logic [MW-1:0] o_mag,
    output logic          o_underflow
);

    logic          w_up;
    logic [MW:0]   w_sum;

    // Round up above the halfway point, or exactly at it when the kept LSB is odd.
    assign w_up  = i_g & (i_s | i_mag[0]);
    assign w_sum = {1'b0, i_mag} + {{MW{1'b0}}, w_up};

    // A carry out can only come from an all-ones input; hold it at maxpos
    // rather than wrapping so the helper is safe for any caller.
    assign o_mag       = w_sum[MW] ? {MW{1'b1}} : w_sum[MW-1:0];
    assign o_underflow = (o_mag == '0);

endmodule
`default_nettype wire

// File: rtl/posit_encoder_32_3.sv
`default_nettype none
// ============================================================================
// Module      : posit_encoder_32_3
// Description : Three-stage pipelined posit(32,3) encoder. Packs sign,
//               regime k, exponent, fraction and sticky into a posit word
//               with round-to-nearest-even and minpos/maxpos saturation.
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid / in_ready   : input handshake
//   in_sign, in_k, in_expo, in_frac, in_sticky, in_zero, in_nar : fields
//   out_valid / out_ready : output handshake
//   out_posit, out_sat    : encoded word, magnitude-clamped flag
// Revision    : 1.0 - initial release
// ============================================================================
module posit_encoder_32_3
    import posit_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [RW-1:0] in_k,
    input  logic [ES-1:0] in_expo,
    input  logic [FS-1:0] in_frac,
    input  logic          in_sticky,
    input  logic          in_zero,
    input  logic          in_nar,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_posit,
    output logic          out_sat
);

    localparam int PADW = XW - 2 - ES - FS;

    // ------------------------------------------------------------------------
    // Handshake: each stage can load when it is empty or its successor is
    // loading this cycle, so bubbles collapse and a full pipe still streams.
    // ------------------------------------------------------------------------
    logic r_v1, r_v2, r_v3;
    logic w_en1, w_en2, w_en3;

    assign w_en3    = ~r_v3 | out_ready;
    assign w_en2    = ~r_v2 | w_en3;
    assign w_en1    = ~r_v1 | w_en2;
    assign in_ready = w_en1;

    // ------------------------------------------------------------------------
    // S1: regime build.
    // k >= 0: "10" followed by the body, arithmetic-shifted right by k,
    //         replicates the leading one into k+1 ones then a zero.
    // k <  0: "01" followed by the body, logically shifted right by -k-1
    //         (which is ~k in two's complement) gives -k zeros then a one.
    // ------------------------------------------------------------------------
    logic signed [XW-1:0] w_base_pos;
    logic signed [XW-1:0] w_x_pos;
    logic        [XW-1:0] w_base_neg;
    logic        [XW-1:0] w_x_neg;
    logic        [XW-1:0] w_x;
    s1_t                  w_s1_d;
    s1_t                  r_s1;

    assign w_base_pos = {2'b10, in_expo, in_frac, {PADW{1'b0}}};
    assign w_base_neg = {2'b01, in_expo, in_frac, {PADW{1'b0}}};
    assign w_x_pos    = w_base_pos >>> in_k;
    assign w_x_neg    = w_base_neg >> (~in_k);
    assign w_x        = in_k[RW-1] ? w_x_neg : $unsigned(w_x_pos);

    always_comb begin
        w_s1_d           = '0;
        w_s1_d.sign      = in_sign;
        w_s1_d.nar       = in_nar;
        w_s1_d.zero      = in_zero;
        w_s1_d.clamp_max = ($signed(in_k) >= K_MAX_CLAMP);
        w_s1_d.clamp_min = ($signed(in_k) <= K_MIN_CLAMP);
        w_s1_d.m         = w_x[XW-1 -: N-1];
        w_s1_d.g         = w_x[XW-N];
        w_s1_d.s         = (|w_x[XW-N-1:0]) | in_sticky;
    end

    // ------------------------------------------------------------------------
    // S2: round to nearest even, then apply clamps. Because the regime always
    // carries a single one bit for non-clamped k, a zero result is only
    // reachable through the helper's generic underflow path.
    // ------------------------------------------------------------------------
    logic [N-2:0] w_m_rnd;
    logic         w_underflow;
    s2_t          w_s2_d;
    s2_t          r_s2;

    posit_round_rne #(
        .MW (N-1)
    ) u_round (
        .i_mag       (r_s1.m),
        .i_g         (r_s1.g),
        .i_s         (r_s1.s),
        .o_mag       (w_m_rnd),
        .o_underflow (w_underflow)
    );

    always_comb begin
        w_s2_d      = '0;
        w_s2_d.sign = r_s1.sign;
        w_s2_d.nar  = r_s1.nar;
        w_s2_d.zero = r_s1.zero;
        if (r_s1.clamp_max) begin
            w_s2_d.m   = MAXPOS[N-2:0];
            w_s2_d.sat = 1'b1;
        end else if (r_s1.clamp_min) begin
            w_s2_d.m   = MINPOS[N-2:0];
            w_s2_d.sat = 1'b1;
        end else if (w_underflow) begin
            w_s2_d.m   = MINPOS[N-2:0];
            w_s2_d.sat = 1'b1;
        end else begin
            w_s2_d.m   = w_m_rnd;
            w_s2_d.sat = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // S3: apply sign; NaR takes priority over zero, and neither is a clamp.
    // ------------------------------------------------------------------------
    logic [N-1:0] w_mag;
    logic [N-1:0] w_posit_d;
    logic         w_sat_d;
    logic [N-1:0] r_posit;
    logic         r_sat;

    assign w_mag = {1'b0, r_s2.m};

    always_comb begin
        w_posit_d = w_mag;
        if (r_s2.nar) begin
            w_posit_d = NAR;
        end else if (r_s2.zero) begin
            w_posit_d = '0;
        end else if (r_s2.sign) begin
            w_posit_d = -w_mag;
        end
    end

    assign w_sat_d = r_s2.sat & ~r_s2.nar & ~r_s2.zero;

    // ------------------------------------------------------------------------
    // Stage registers. Payloads only move when a valid item moves, so the
    // output word holds still while the consumer stalls.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_posit <= '0;
            r_sat   <= 1'b0;
        end else begin
            if (w_en1) begin
                r_v1 <= in_valid;
                if (in_valid) begin
                    r_s1 <= w_s1_d;
                end
            end
            if (w_en2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_s2 <= w_s2_d;
                end
            end
            if (w_en3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_posit <= w_posit_d;
                    r_sat   <= w_sat_d;
                end
            end
        end
    end

    assign out_valid = r_v3;
    assign out_posit = r_posit;
    assign out_sat   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_posit_encoder_32_3.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_posit_encoder_32_3
// Description : Scoreboard bench for posit_encoder_32_3. Stimulus pushes the
//               hand-derived expected word on each accepted input; a monitor
//               pops and compares on every output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_posit_encoder_32_3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [5:0]  in_k;
    logic [2:0]  in_expo;
    logic [25:0] in_frac;
    logic        in_sticky;
    logic        in_zero;
    logic        in_nar;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_posit;
    logic        out_sat;

    always #5 clk = ~clk;

    posit_encoder_32_3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_k      (in_k),
        .in_expo   (in_expo),
        .in_frac   (in_frac),
        .in_sticky (in_sticky),
        .in_zero   (in_zero),
        .in_nar    (in_nar),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_posit (out_posit),
        .out_sat   (out_sat)
    );

    typedef struct packed {
        logic [31:0] posit;
        logic        sat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // k = 0: string is 0|10|eee|f...f with no dropped bits
    function automatic logic [31:0] exp_k0(input logic s, input logic [2:0] e, input logic [25:0] f);
        logic [31:0] mag;
        mag = {3'b010, e, f};
        return s ? -mag : mag;
    endfunction

    // k = -1: string is 0|01|eee|f...f with no dropped bits
    function automatic logic [31:0] exp_km1(input logic s, input logic [2:0] e, input logic [25:0] f);
        logic [31:0] mag;
        mag = {3'b001, e, f};
        return s ? -mag : mag;
    endfunction

    // ---------------- monitor ----------------
    logic        hold_pend = 1'b0;
    logic [31:0] hold_posit;
    logic        hold_sat;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && out_valid) begin
                chk("hold_posit", out_posit, hold_posit);
                chk("hold_sat", {31'b0, out_sat}, {31'b0, hold_sat});
            end
            hold_pend  = out_valid & ~out_ready;
            hold_posit = out_posit;
            hold_sat   = out_sat;
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got posit %h, required no output", out_posit);
                end else begin
                    e = q.pop_front();
                    chk("posit", out_posit, e.posit);
                    chk("sat", {31'b0, out_sat}, {31'b0, e.sat});
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic s, input logic [5:0] k, input logic [2:0] e,
                         input logic [25:0] f, input logic st, input logic z, input logic n);
        in_sign   = s;
        in_k      = k;
        in_expo   = e;
        in_frac   = f;
        in_sticky = st;
        in_zero   = z;
        in_nar    = n;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic s, input logic [5:0] k, input logic [2:0] e,
                        input logic [25:0] f, input logic st, input logic z, input logic n,
                        input logic [31:0] ep, input logic es);
        int t;
        bit ok;
        ok = 1'b0;
        drive(s, k, e, f, st, z, n);
        in_valid = 1'b1;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", t);
        end else begin
            q.push_back({ep, es});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges from the accepting edge until out_valid is seen.
    task automatic measure_lat(output int lat);
        lat = 1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            #1;
            lat++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int t = 0; t < 50 && q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk(name, q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int  lat;
        int  idx;
        int  occ;
        int  base_out;
        int  stale;
        bit  saw_low;
        bit  acc;
        bit  fire;

        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(0, 6'd0, 3'd0, 26'd0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_posit", out_posit, 32'd0);
        chk("rst_out_sat", {31'b0, out_sat}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single item latency
        send(0, 6'd0, 3'd0, 26'd0, 0, 0, 0, 32'h4000_0000, 1'b0);
        measure_lat(lat);
        chk("latency", lat, 32'd3);
        wait_drain("drain_first");

        // Directed vectors, back to back
        send(1, 6'd0,  3'd0,   26'd0, 0, 0, 0, 32'hC000_0000, 1'b0);
        send(0, 6'h3F, 3'd0,   26'd0, 0, 0, 0, 32'h2000_0000, 1'b0);
        send(0, 6'd29, 3'b100, 26'd0, 0, 0, 0, 32'h7FFF_FFFE, 1'b0);
        send(0, 6'd29, 3'b101, 26'd0, 0, 0, 0, 32'h7FFF_FFFF, 1'b0);
        send(0, 6'd31, 3'd0,   26'd0, 0, 0, 0, 32'h7FFF_FFFF, 1'b1);
        send(0, 6'd30, 3'd0,   26'd0, 0, 0, 0, 32'h7FFF_FFFF, 1'b1);
        send(1, 6'h20, 3'd0,   26'd0, 0, 0, 0, 32'hFFFF_FFFF, 1'b1);
        send(0, 6'h21, 3'd0,   26'd0, 0, 0, 0, 32'h0000_0001, 1'b1);
        send(0, 6'h22, 3'd0,   26'd0, 0, 0, 0, 32'h0000_0001, 1'b0);
        send(0, 6'h22, 3'd7,   26'd0, 0, 0, 0, 32'h0000_0002, 1'b0);
        send(1, 6'h22, 3'd0,   26'd0, 0, 0, 0, 32'hFFFF_FFFF, 1'b0);
        send(0, 6'd1,  3'd0,   26'h1, 0, 0, 0, 32'h6000_0000, 1'b0);
        send(0, 6'd1,  3'd0,   26'h3, 0, 0, 0, 32'h6000_0002, 1'b0);
        send(0, 6'd1,  3'd0,   26'h1, 1, 0, 0, 32'h6000_0001, 1'b0);
        send(1, 6'd1,  3'd0,   26'h1, 1, 0, 0, 32'h9FFF_FFFF, 1'b0);
        send(0, 6'd0,  3'b101, 26'h2AAAAAA, 1, 0, 0, 32'h56AA_AAAA, 1'b0);
        send(0, 6'h3F, 3'd7,   26'h3FFFFFF, 0, 0, 0, 32'h3FFF_FFFF, 1'b0);
        send(1, 6'h3F, 3'd7,   26'h3FFFFFF, 0, 0, 0, 32'hC000_0001, 1'b0);
        send(0, 6'd5,  3'd0,   26'd0, 0, 1, 1, 32'h8000_0000, 1'b0);
        send(1, 6'd31, 3'd0,   26'd0, 0, 0, 1, 32'h8000_0000, 1'b0);
        send(1, 6'd31, 3'd0,   26'd0, 0, 1, 0, 32'h0000_0000, 1'b0);
        wait_drain("drain_directed");

        // Backpressure: 8 items, out_ready low in cycles 4..9
        idx      = 0;
        occ      = 0;
        saw_low  = 1'b0;
        base_out = n_out;
        for (int c = 0; c < 80 && (n_out - base_out) < 8; c++) begin
            out_ready = !(c >= 4 && c <= 9);
            if (idx < 8) begin
                drive(idx[0], 6'd0, idx[2:0], 26'(idx * 32'h0123457), 0, 0, 0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk("bp_in_ready", {31'b0, in_ready}, {31'b0, (occ < 3) || out_ready});
            if (!in_ready) saw_low = 1'b1;
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (acc) begin
                q.push_back({exp_k0(idx[0], idx[2:0], 26'(idx * 32'h0123457)), 1'b0});
                idx++;
            end
            occ = occ + int'(acc) - int'(fire);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_saw_in_ready_low", {31'b0, saw_low}, 32'd1);
        chk("bp_count", n_out - base_out, 32'd8);
        wait_drain("drain_bp");

        // Full throughput: 20 items on consecutive cycles
        base_out = n_out;
        for (int c = 0; c < 23; c++) begin
            if (c < 20) begin
                drive(c[0], 6'h3F, c[2:0], 26'(c * 32'h00ABCDE), 0, 0, 0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 20) begin
                chk("tp_in_ready", {31'b0, in_ready}, 32'd1);
                if (in_ready) q.push_back({exp_km1(c[0], c[2:0], 26'(c * 32'h00ABCDE)), 1'b0});
            end
            if (c >= 3) chk("tp_out_valid", {31'b0, out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_drain("drain_tp");
        chk("tp_count", n_out - base_out, 32'd20);

        // Reset with 3 items in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 6'd0, 3'(i), 26'h155, 0, 0, 0);
            in_valid = 1'b1;
            @(negedge clk);
            chk("rst_fill_in_ready", {31'b0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_pre_valid", {31'b0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_async_in_ready", {31'b0, in_ready}, 32'd1);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stale     = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (out_valid) stale++;
            @(posedge clk);
            #1;
        end
        chk("rst_no_stale", stale, 32'd0);

        send(1, 6'd0, 3'd3, 26'h0000ABC, 0, 0, 0, exp_k0(1'b1, 3'd3, 26'h0000ABC), 1'b0);
        measure_lat(lat);
        chk("rst_fresh_latency", lat, 32'd3);
        wait_drain("drain_fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
